fifo_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/bit_timer.sv | 39 +++
 rtl/fifo_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Holds the frame FSM states, parity modes and frame-length math.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int frame_len(
        input int cpb,
        input int data_bits,
        input int parity,
        input int stop_bits
    );
        int par_bits;
        par_bits = (parity != PARITY_NONE) ? 1 : 0;
        return (1 + data_bits + par_bits + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Clock-per-bit counter for the UART serializer.
// Holds at zero while disabled; ticks on the last clock of each bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next count: clear when idle or at the bit boundary, else advance.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops a byte when idle and sends
// start, data LSB first, optional parity and stop bits on tx.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] fifo_rdata,
    input  logic       fifo_empty,
    output logic       fifo_ren,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [7:0] DMASK     = 8'((1 << DATA_BITS) - 1);
    localparam bit         HAS_PAR   = (PARITY != PARITY_NONE);
    localparam logic       PAR_ODD   = (PARITY == PARITY_ODD);

    tx_state_t  state_q;
    tx_state_t  state_d;
    logic [7:0] sh_q;
    logic [7:0] sh_d;
    logic [2:0] bit_q;
    logic [2:0] bit_d;
    logic       par_q;
    logic       par_d;
    logic       tx_q;
    logic       tx_d;
    logic       tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

    assign fifo_ren = rst_n && (state_q == IDLE) && en && !fifo_empty;
    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == STOP) && tick && (bit_q == LAST_STOP);

    // Frame sequencing: every transition happens on a bit boundary,
    // except the pop itself which leaves IDLE immediately.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        par_d   = par_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                bit_d = '0;
                if (fifo_ren) begin
                    sh_d    = fifo_rdata & DMASK;
                    par_d   = (^(fifo_rdata & DMASK)) ^ PAR_ODD;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = sh_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            tx_d    = par_q;
                            state_d = uart_pkg::PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, shifter and line registers; reset idles the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

`ifdef FORMAL
    localparam int FLEN = frame_len(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS);

    int unsigned flen_q;

    // Cycles spent busy in the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flen_q <= '0;
        end else if (!busy) begin
            flen_q <= '0;
        end else begin
            flen_q <= flen_q + 1;
        end
    end

    a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_ren && fifo_empty));
    a_pop_idle: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_ren |-> (state_q == IDLE));
    a_busy_no_pop: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> !fifo_ren);
    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !busy);
    a_tx_high: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == IDLE) || (state_q == STOP)) |-> tx);
    a_frame_len: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> (flen_q == FLEN - 1));
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four parameter variants share one FIFO model;
// expected frames are queued on push and checked as each frame is sent.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct packed {
        logic [3:0]  nbits;
        logic [11:0] bits;
    } frame_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        frame_t     f;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] en_r = '0;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    wire  [3:0] ren_w;
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;

    logic [7:0] fifo_q[$];
    frame_t     exp_q[$];
    vec_t       vecs[8];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en_r[0]),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ren(ren_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en_r[1]),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ren(ren_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en_r[2]),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ren(ren_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en_r[3]),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ren(ren_w[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic fifo_push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_sync();
    endtask

    function automatic frame_t mkf(input int n, input logic [11:0] b);
        frame_t f;
        f.nbits = 4'(n);
        f.bits  = b;
        return f;
    endfunction

    // Waits for the pop of variant sel, then checks the whole frame
    // against the next scoreboard entry (first bit held at bits[nbits-1]).
    task automatic run_frame(input int sel, input int drop_at,
                             output int pop_cyc, output int waited);
        frame_t     f;
        int         nb;
        int         len;
        int         k;
        int         busy_n;
        int         done_n;
        int         done_at;
        int         ren_n;
        logic [3:0] tx4;
        logic [3:0] exp4;
        waited  = 0;
        pop_cyc = -1;
        #1;
        while (!ren_w[sel] && waited < 60) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check($sformatf("u%0d_pop_strobe", sel), int'(ren_w[sel]), 1);
        if (!ren_w[sel]) return;
        check($sformatf("u%0d_pop_nonempty", sel), int'(fifo_empty), 0);
        pop_cyc = cyc;
        @(posedge clk);
        #1;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_sync();
        if (exp_q.size() == 0) return;
        f       = exp_q.pop_front();
        nb      = int'(f.nbits);
        len     = nb * CPB;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        ren_n   = 0;
        for (int b = 0; b < nb; b++) begin
            exp4 = f.bits[nb-1-b] ? 4'hF : 4'h0;
            tx4  = '0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                k = b * CPB + c + 1;
                if (k == drop_at) en_r[sel] = 1'b0;
                tx4[c] = tx_w[sel];
                if (busy_w[sel]) busy_n++;
                if (ren_w[sel]) ren_n++;
                if (done_w[sel]) begin
                    done_n++;
                    done_at = k;
                end
            end
            check($sformatf("u%0d_tx_bit%0d", sel, b), int'(tx4), int'(exp4));
        end
        check($sformatf("u%0d_busy_cycles", sel), busy_n, len);
        check($sformatf("u%0d_done_count", sel), done_n, 1);
        check($sformatf("u%0d_done_at", sel), done_at, len);
        check($sformatf("u%0d_pop_in_frame", sel), ren_n, 0);
    endtask

    task automatic idle_check(input int sel, input string tag);
        @(negedge clk);
        #1;
        check({tag, "_idle_busy"}, int'(busy_w[sel]), 0);
        check({tag, "_idle_tx"}, int'(tx_w[sel]), 1);
        check({tag, "_idle_done"}, int'(done_w[sel]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1;
        int p2;
        int w;
        int n_ren;
        int n_busy;
        int n_done;
        int n_txlo;

        vecs[0] = '{sel: 2'd0, data: 8'hA5, f: mkf(10, 12'b0101001011)};
        vecs[1] = '{sel: 2'd1, data: 8'hA5, f: mkf(11, 12'b01010010101)};
        vecs[2] = '{sel: 2'd2, data: 8'hA5, f: mkf(11, 12'b01010010111)};
        vecs[3] = '{sel: 2'd3, data: 8'hA5, f: mkf(11, 12'b01010010111)};
        vecs[4] = '{sel: 2'd1, data: 8'h07, f: mkf(11, 12'b01110000011)};
        vecs[5] = '{sel: 2'd2, data: 8'h00, f: mkf(11, 12'b00000000011)};
        vecs[6] = '{sel: 2'd0, data: 8'hFF, f: mkf(10, 12'b0111111111)};
        vecs[7] = '{sel: 2'd3, data: 8'h5A, f: mkf(11, 12'b00101101011)};

        fifo_sync();

        // Reset: outputs idle, no pop even with data waiting and en high.
        fifo_push(8'hA5);
        en_r = 4'hF;
        @(negedge clk);
        #1;
        check("rst_ren", int'(ren_w), 0);
        check("rst_tx", int'(tx_w), 15);
        check("rst_busy", int'(busy_w), 0);
        check("rst_done", int'(done_w), 0);
        en_r = '0;
        fifo_q.delete();
        fifo_sync();
        @(negedge clk);
        rst_n = 1'b1;

        // Single frames across all variants.
        for (int i = 0; i < 8; i++) begin
            fifo_push(vecs[i].data);
            exp_q.push_back(vecs[i].f);
            en_r[vecs[i].sel] = 1'b1;
            run_frame(int'(vecs[i].sel), 0, p1, w);
            en_r[vecs[i].sel] = 1'b0;
            idle_check(int'(vecs[i].sel), $sformatf("vec%0d", i));
        end

        // Back-to-back pops are one frame plus one idle cycle apart.
        fifo_push(8'h01);
        fifo_push(8'h80);
        exp_q.push_back(mkf(10, 12'b0100000001));
        exp_q.push_back(mkf(10, 12'b0000000011));
        en_r[0] = 1'b1;
        run_frame(0, 0, p1, w);
        run_frame(0, 0, p2, w);
        check("b2b_pop_spacing", p2 - p1, 41);
        en_r[0] = 1'b0;
        idle_check(0, "b2b");

        // Empty FIFO with en high: nothing moves for 100 cycles.
        en_r[0] = 1'b1;
        n_ren = 0; n_busy = 0; n_done = 0; n_txlo = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (ren_w[0]) n_ren++;
            if (busy_w[0]) n_busy++;
            if (done_w[0]) n_done++;
            if (!tx_w[0]) n_txlo++;
        end
        check("empty_ren", n_ren, 0);
        check("empty_busy", n_busy, 0);
        check("empty_done", n_done, 0);
        check("empty_tx_low", n_txlo, 0);
        en_r[0] = 1'b0;

        // Reset mid-frame drops the byte; the next one pops right away.
        fifo_push(8'h00);
        fifo_push(8'h55);
        exp_q.push_back(mkf(10, 12'b0101010101));
        en_r[0] = 1'b1;
        #1;
        w = 0;
        while (!ren_w[0] && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("rst_mid_pop", int'(ren_w[0]), 1);
        @(posedge clk);
        #1;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_sync();
        repeat (15) @(negedge clk);
        #1;
        check("rst_mid_tx_before", int'(tx_w[0]), 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", int'(tx_w[0]), 1);
        check("rst_mid_busy", int'(busy_w[0]), 0);
        check("rst_mid_done", int'(done_w[0]), 0);
        check("rst_mid_ren", int'(ren_w[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 0, p1, w);
        check("rst_mid_repop_wait", w, 0);
        en_r[0] = 1'b0;
        idle_check(0, "rst_mid");

        // en dropped mid-frame: frame completes, then no pops until re-raised.
        fifo_push(8'h11);
        fifo_push(8'h22);
        fifo_push(8'h33);
        exp_q.push_back(mkf(10, 12'b0100010001));
        exp_q.push_back(mkf(10, 12'b0010001001));
        exp_q.push_back(mkf(10, 12'b0110011001));
        en_r[0] = 1'b1;
        run_frame(0, 10, p1, w);
        check("endrop_en_low", int'(en_r[0]), 0);
        n_ren = 0; n_busy = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (ren_w[0]) n_ren++;
            if (busy_w[0]) n_busy++;
        end
        check("endrop_no_pop", n_ren, 0);
        check("endrop_no_busy", n_busy, 0);
        en_r[0] = 1'b1;
        run_frame(0, 0, p1, w);
        check("endrop_repop_wait", w, 0);
        run_frame(0, 0, p2, w);
        check("endrop_spacing", p2 - p1, 41);
        en_r[0] = 1'b0;
        idle_check(0, "endrop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
